// File: rtl/avl_stream_pkt_rx_if.sv
// Packet stream interface: data beat with sop/eop framing, byte-empty count and
// channel, plus ready/almost_full flowing back from the receiver.
interface avl_stream_if #(
    parameter int WIDTH  = 512,
    parameter int MAX_CH = 4
);
    localparam int EW = $clog2(WIDTH / 8);
    localparam int CW = $clog2(MAX_CH);

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             sop;
    logic             eop;
    logic [EW-1:0]    empty;
    logic [CW-1:0]    channel;
    logic             ready;
    logic             almost_full;

    modport tx (output data, valid, sop, eop, empty, channel, input  ready, almost_full);
    modport rx (input  data, valid, sop, eop, empty, channel, output ready, almost_full);

    modport master (output data, valid, sop, eop, empty, channel, input  ready, almost_full);
    modport slave  (input  data, valid, sop, eop, empty, channel, output ready, almost_full);
endinterface

// File: rtl/avl_stream_pkt_rx.sv
// Ingress endpoint for a packet stream: repairs sop/eop/channel framing on the
// way in, buffers beats in a FIFO and replays clean packets on the output.
//
//  state   | meaning
//  IDLE    | rx: between packets, next accepted beat must carry sop
//  IN_PKT  | rx: packet open, channel latched from its sop beat
//  TX_IDLE | tx: FIFO head is a sop beat, may be held by downstream almost_full
//  TX_PKT  | tx: packet in progress on the output, never paused
module avl_stream_pkt_rx #(
    parameter int WIDTH       = 512,
    parameter int MAX_CH      = 4,
    parameter int DEPTH       = 32,
    parameter int AF_MARGIN   = 8,
    parameter bit PAUSE_ON_AF = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    avl_stream_if.rx     in_if,
    avl_stream_if.tx     out_if,
    output logic [31:0]  pkt_cnt,
    output logic [15:0]  err_nosop,
    output logic [15:0]  err_dupsop,
    output logic [15:0]  err_chan
);
    localparam int EW = $clog2(WIDTH / 8);
    localparam int CW = $clog2(MAX_CH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW + 1)'(DEPTH - AF_MARGIN);

    typedef enum logic { IDLE, IN_PKT } rx_state_t;
    typedef enum logic { TX_IDLE, TX_PKT } tx_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
        logic [EW-1:0]    empty;
        logic [CW-1:0]    channel;
    } beat_t;

    rx_state_t     rx_state, rx_next;
    tx_state_t     tx_state, tx_next;
    beat_t         mem [DEPTH];
    beat_t         wbeat;
    beat_t         head;
    logic [AW:0]   wr_ptr, rd_ptr, wr_vis;
    logic [AW:0]   wr_ptr_nx, rd_ptr_nx, occ_nx;
    logic [CW-1:0] ch_latched;
    logic          rdy_q, af_q;
    logic          push, pop, ch_load;
    logic          inc_pkt, inc_nosop, inc_dup, inc_chan;
    logic          head_avail, hold, out_valid;

    assign in_if.ready       = rdy_q;
    assign in_if.almost_full = af_q;

    // Rx framing: decide whether an accepted beat is written and how it is repaired.
    always_comb begin
        rx_next       = rx_state;
        push          = 1'b0;
        ch_load       = 1'b0;
        inc_pkt       = 1'b0;
        inc_nosop     = 1'b0;
        inc_dup       = 1'b0;
        inc_chan      = 1'b0;
        wbeat.data    = in_if.data;
        wbeat.sop     = 1'b0;
        wbeat.eop     = in_if.eop;
        wbeat.empty   = in_if.eop ? in_if.empty : '0;
        wbeat.channel = in_if.channel;
        if (in_if.valid && rdy_q) begin
            case (rx_state)
                IDLE: begin
                    if (!in_if.sop) begin
                        inc_nosop = 1'b1;
                    end else begin
                        push      = 1'b1;
                        wbeat.sop = 1'b1;
                        ch_load   = 1'b1;
                        if (in_if.eop) inc_pkt = 1'b1;
                        else           rx_next = IN_PKT;
                    end
                end
                IN_PKT: begin
                    push          = 1'b1;
                    wbeat.channel = ch_latched;
                    if (in_if.sop) inc_dup = 1'b1;
                    if (in_if.channel != ch_latched) inc_chan = 1'b1;
                    if (in_if.eop) begin
                        inc_pkt = 1'b1;
                        rx_next = IDLE;
                    end
                end
                default: rx_next = IDLE;
            endcase
        end
    end

    // The read side sees the write pointer one cycle late, giving one cycle of
    // pass-through latency and keeping head fields stable while stalled.
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_avail = (rd_ptr != wr_vis);
    assign hold       = (tx_state == TX_IDLE) && PAUSE_ON_AF && out_if.almost_full;
    assign out_valid  = head_avail && !hold;
    assign pop        = out_valid && out_if.ready;

    assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, pop};
    assign occ_nx    = wr_ptr_nx - rd_ptr_nx;

    // Output fields are zero whenever nothing is visible, including right after reset.
    always_comb begin
        out_if.valid   = out_valid;
        out_if.data    = '0;
        out_if.sop     = 1'b0;
        out_if.eop     = 1'b0;
        out_if.empty   = '0;
        out_if.channel = '0;
        if (head_avail) begin
            out_if.data    = head.data;
            out_if.sop     = head.sop;
            out_if.eop     = head.eop;
            out_if.empty   = head.empty;
            out_if.channel = head.channel;
        end
    end

    // Tx packet tracking: only the boundary between packets may be paused.
    always_comb begin
        tx_next = tx_state;
        if (pop) begin
            if (head.eop)      tx_next = TX_IDLE;
            else if (head.sop) tx_next = TX_PKT;
        end
    end

    // FIFO storage; no reset needed since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wbeat;
    end

    // State, pointers, flow-control flags and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= IDLE;
            tx_state   <= TX_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_vis     <= '0;
            rdy_q      <= 1'b0;
            af_q       <= 1'b0;
            ch_latched <= '0;
            pkt_cnt    <= '0;
            err_nosop  <= '0;
            err_dupsop <= '0;
            err_chan   <= '0;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            wr_vis   <= wr_ptr;
            rdy_q    <= (occ_nx != FULL_LVL);
            af_q     <= (occ_nx >= AF_LVL);
            if (ch_load) ch_latched <= in_if.channel;
            if (inc_pkt) pkt_cnt <= pkt_cnt + 32'd1;
            if (inc_nosop && (err_nosop != '1))  err_nosop  <= err_nosop + 16'd1;
            if (inc_dup   && (err_dupsop != '1)) err_dupsop <= err_dupsop + 16'd1;
            if (inc_chan  && (err_chan != '1))   err_chan   <= err_chan + 16'd1;
        end
    end
endmodule

// File: tb/tb_avl_stream_pkt_rx.sv
// Bench for avl_stream_pkt_rx: directed framing/flow-control sequences, a table
// of error-repair vectors and a randomized run against a queue-based model.
module tb_avl_stream_pkt_rx;
    localparam int WIDTH     = 512;
    localparam int MAX_CH    = 4;
    localparam int DEPTH     = 32;
    localparam int AF_MARGIN = 8;
    localparam bit PAUSE     = 1'b1;
    localparam int EW        = $clog2(WIDTH / 8);
    localparam int CW        = $clog2(MAX_CH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    avl_stream_if #(.WIDTH(WIDTH), .MAX_CH(MAX_CH)) in_if ();
    avl_stream_if #(.WIDTH(WIDTH), .MAX_CH(MAX_CH)) out_if ();

    logic [31:0] pkt_cnt;
    logic [15:0] err_nosop, err_dupsop, err_chan;

    avl_stream_pkt_rx #(
        .WIDTH(WIDTH), .MAX_CH(MAX_CH), .DEPTH(DEPTH),
        .AF_MARGIN(AF_MARGIN), .PAUSE_ON_AF(PAUSE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (in_if),
        .out_if     (out_if),
        .pkt_cnt    (pkt_cnt),
        .err_nosop  (err_nosop),
        .err_dupsop (err_dupsop),
        .err_chan   (err_chan)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        bit               sop;
        bit               eop;
        logic [EW-1:0]    empty;
        logic [CW-1:0]    ch;
        int               pe;
    } mbeat_t;

    mbeat_t        q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            m_init = 0, m_rdy_ok = 0, m_in_pkt = 0, m_tx_pkt = 0;
    logic [CW-1:0] m_ch = '0;
    int            edge_cnt = 0;
    logic [31:0]   m_pkt = '0;
    logic [15:0]   m_nosop = '0, m_dup = '0, m_chan = '0;
    int            n_out = 0, n_out_eop = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: checks last edge's outcome, then applies the coming edge.
    always @(negedge clk) begin : mon
        mbeat_t mb;
        bit     exp_valid;
        if (m_init) begin
            chk("in_ready", in_if.ready, m_rdy_ok && (q.size() != DEPTH));
            chk("in_almost_full", in_if.almost_full, q.size() >= DEPTH - AF_MARGIN);
            exp_valid = (q.size() > 0) && (edge_cnt > q[0].pe) &&
                        !(!m_tx_pkt && PAUSE && out_if.almost_full);
            chk("out_valid", out_if.valid, exp_valid);
            chk("counters", {pkt_cnt, err_nosop, err_dupsop, err_chan},
                {m_pkt, m_nosop, m_dup, m_chan});
        end
        if (!rst_n) begin
            q.delete();
            m_init = 1; m_rdy_ok = 0; m_in_pkt = 0; m_tx_pkt = 0; m_ch = '0;
            m_pkt = '0; m_nosop = '0; m_dup = '0; m_chan = '0;
        end else if (m_init) begin
            if (out_if.valid && out_if.ready && q.size() > 0) begin
                mb = q.pop_front();
                chk("out_meta", {out_if.sop, out_if.eop, out_if.empty, out_if.channel},
                    {mb.sop, mb.eop, mb.empty, mb.ch});
                n_tests++;
                if (out_if.data !== mb.data) begin
                    n_fail++;
                    $display("FAIL out_data: got %h expected %h (low 64 bits)",
                             out_if.data[63:0], mb.data[63:0]);
                end
                n_out++;
                if (mb.eop) begin m_tx_pkt = 0; n_out_eop++; end
                else if (mb.sop) m_tx_pkt = 1;
            end
            if (in_if.valid && in_if.ready) begin
                mb.data = in_if.data;
                mb.eop  = in_if.eop;
                mb.empty = in_if.eop ? in_if.empty : '0;
                mb.pe   = edge_cnt + 1;
                if (!m_in_pkt) begin
                    if (!in_if.sop) begin
                        if (m_nosop != 16'hFFFF) m_nosop++;
                    end else begin
                        mb.sop = 1; mb.ch = in_if.channel; m_ch = in_if.channel;
                        q.push_back(mb);
                        if (in_if.eop) m_pkt++; else m_in_pkt = 1;
                    end
                end else begin
                    if (in_if.sop && m_dup != 16'hFFFF) m_dup++;
                    if (in_if.channel != m_ch && m_chan != 16'hFFFF) m_chan++;
                    mb.sop = 0; mb.ch = m_ch;
                    q.push_back(mb);
                    if (in_if.eop) begin m_pkt++; m_in_pkt = 0; end
                end
            end
            m_rdy_ok = 1;
        end
        edge_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_beat(input bit v, input bit s, input bit e, input logic [EW-1:0] emp,
                            input logic [CW-1:0] ch, input logic [31:0] tag);
        in_if.valid = v; in_if.sop = s; in_if.eop = e;
        in_if.empty = emp; in_if.channel = ch; in_if.data = {16{tag}};
    endtask

    task automatic send(input bit s, input bit e, input logic [EW-1:0] emp,
                        input logic [CW-1:0] ch, input logic [31:0] tag);
        bit acc;
        int t;
        acc = 0; t = 0;
        set_beat(1, s, e, emp, ch, tag);
        while (!acc && t < 300) begin
            @(negedge clk); acc = in_if.ready;
            @(posedge clk); #1; t++;
        end
        in_if.valid = 0;
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic do_reset();
        in_if.valid = 0;
        rst_n = 0;
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (q.size() != 0 && t < budget) begin tick(); t++; end
        chk("drain_left", q.size(), 0);
        tick(); tick();
    endtask

    typedef struct {
        bit            s;
        bit            e;
        logic [CW-1:0] ch;
        logic [15:0]   en, ed, ec;
        logic [31:0]   ep;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int base_out, base_eop, acc, low, tag;
        bit a, gen_pkt;
        logic [CW-1:0] gch, chv;
        bit s, e;

        // nosop, open, dupsop, chan change, close, single-beat, open, dupsop+chan+close
        vecs[0] = '{0, 0, 2'd2, 16'd1, 16'd0, 16'd0, 32'd0};
        vecs[1] = '{1, 0, 2'd2, 16'd1, 16'd0, 16'd0, 32'd0};
        vecs[2] = '{1, 0, 2'd2, 16'd1, 16'd1, 16'd0, 32'd0};
        vecs[3] = '{0, 0, 2'd3, 16'd1, 16'd1, 16'd1, 32'd0};
        vecs[4] = '{0, 1, 2'd2, 16'd1, 16'd1, 16'd1, 32'd1};
        vecs[5] = '{1, 1, 2'd1, 16'd1, 16'd1, 16'd1, 32'd2};
        vecs[6] = '{1, 0, 2'd0, 16'd1, 16'd1, 16'd1, 32'd2};
        vecs[7] = '{1, 1, 2'd3, 16'd1, 16'd2, 16'd2, 32'd3};

        set_beat(0, 0, 0, '0, '0, 32'd0);
        out_if.ready = 1; out_if.almost_full = 0;

        // 1: three-beat packet, latency and field pass-through
        do_reset();
        chk("t1_reset_cnt", {pkt_cnt, err_nosop, err_dupsop, err_chan}, 80'd0);
        chk("t1_reset_out", {out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.channel}, 0);
        base_eop = n_out_eop;
        send(1, 0, 6'd3, 2'd2, 32'h100);
        chk("t1_lat_n", out_if.valid, 0);
        send(0, 0, 6'd3, 2'd2, 32'h101);
        chk("t1_lat_n1", out_if.valid, 1);
        send(0, 1, 6'd5, 2'd2, 32'h102);
        drain(50);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_eops", n_out_eop - base_eop, 1);

        // 2: backpressure, full and almost_full thresholds
        out_if.ready = 0;
        do_reset();
        base_out = n_out; base_eop = n_out_eop; acc = 0;
        for (int c = 0; c < 45; c++) begin
            set_beat(1, acc == 0, 0, '0, 2'd1, 32'h200 + acc);
            @(negedge clk); a = in_if.ready;
            @(posedge clk); #1;
            if (a) begin
                acc++;
                if (acc == 23) chk("t2_af_at_23", in_if.almost_full, 0);
                if (acc == 24) chk("t2_af_at_24", in_if.almost_full, 1);
            end
        end
        in_if.valid = 0;
        chk("t2_accepted", acc, 32);
        chk("t2_ready_low", in_if.ready, 0);
        out_if.ready = 1;
        for (int i = 32; i < 40; i++) send(0, i == 39, 6'd7, 2'd1, 32'h200 + i);
        drain(200);
        chk("t2_beats_out", n_out - base_out, 40);
        chk("t2_eops", n_out_eop - base_eop, 1);

        // 3: framing repair vectors
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].s, vecs[i].e, 6'd4, vecs[i].ch, 32'h300 + i);
            chk($sformatf("t3_vec%0d", i), {err_nosop, err_dupsop, err_chan, pkt_cnt},
                {vecs[i].en, vecs[i].ed, vecs[i].ec, vecs[i].ep});
        end
        drain(50);

        // 4: downstream almost_full pauses only between packets
        do_reset();
        base_eop = n_out_eop;
        send(1, 0, 6'd0, 2'd1, 32'h400);
        tick(); tick(); tick();
        out_if.almost_full = 1;
        send(0, 0, 6'd0, 2'd1, 32'h401);
        send(0, 1, 6'd2, 2'd1, 32'h402);
        send(1, 0, 6'd0, 2'd2, 32'h410);
        send(0, 1, 6'd9, 2'd2, 32'h411);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_a_done", n_out_eop - base_eop, 1);
        chk("t4_b_held", out_if.valid, 0);
        out_if.almost_full = 0;
        drain(50);
        chk("t4_b_done", n_out_eop - base_eop, 2);

        // 5: reset with ten beats buffered
        out_if.ready = 0;
        do_reset();
        send(0, 0, 6'd0, 2'd0, 32'h500);
        send(1, 0, 6'd0, 2'd0, 32'h501);
        send(0, 1, 6'd1, 2'd0, 32'h502);
        send(1, 0, 6'd0, 2'd3, 32'h503);
        for (int i = 0; i < 7; i++) send(0, 0, 6'd0, 2'd3, 32'h504 + i);
        chk("t5_pre_pkt", pkt_cnt, 1);
        do_reset();
        chk("t5_out_valid", out_if.valid, 0);
        chk("t5_counters", {pkt_cnt, err_nosop, err_dupsop, err_chan}, 80'd0);
        out_if.ready = 1;
        base_eop = n_out_eop;
        send(1, 0, 6'd0, 2'd2, 32'h520);
        send(0, 0, 6'd0, 2'd2, 32'h521);
        send(0, 1, 6'd8, 2'd2, 32'h522);
        drain(50);
        chk("t5_pkt_cnt", pkt_cnt, 1);
        chk("t5_eops", n_out_eop - base_eop, 1);

        // 6: full FIFO streaming with simultaneous push and pop
        out_if.ready = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(i == 0, 0, 6'd0, 2'd1, 32'h600 + i);
        out_if.ready = 1;
        tag = 32'h600 + DEPTH; low = 0;
        for (int c = 0; c < 100; c++) begin
            set_beat(1, 0, 0, '0, 2'd1, tag);
            @(negedge clk); a = in_if.ready;
            if (c >= 1 && !a) low++;
            @(posedge clk); #1;
            if (a) tag++;
        end
        in_if.valid = 0;
        chk("t6_ready_gaps", low, 0);
        chk("t6_af", in_if.almost_full, 1);
        send(0, 1, 6'd1, 2'd1, tag);
        drain(100);

        // 7: randomized traffic against the model
        do_reset();
        gen_pkt = 0; gch = '0; tag = 32'h7000; a = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_if.valid || a) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_if.valid = 0;
                end else begin
                    if (!gen_pkt) s = ($urandom_range(0, 9) != 0);
                    else          s = ($urandom_range(0, 19) == 0);
                    e = (gen_pkt || s) ? ($urandom_range(0, 4) == 0) : 1'b0;
                    if (s && !gen_pkt) gch = CW'($urandom_range(0, MAX_CH - 1));
                    chv = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(0, MAX_CH - 1)) : gch;
                    if (!gen_pkt && s) gen_pkt = !e;
                    else if (gen_pkt && e) gen_pkt = 0;
                    set_beat(1, s, e, EW'($urandom_range(0, 63)), chv, tag);
                    tag++;
                end
            end
            if (((c / 400) % 3) == 1) out_if.ready = ($urandom_range(0, 9) < 2);
            else                      out_if.ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) out_if.almost_full = ~out_if.almost_full;
            @(negedge clk); a = in_if.valid && in_if.ready;
            @(posedge clk); #1;
        end
        in_if.valid = 0;
        out_if.ready = 1;
        out_if.almost_full = 0;
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
